// File: rtl/pipeline_scoreboard_if.sv
// ID-stage request and scoreboard response bundle for the hazard/forwarding scoreboard.
interface pipeline_scoreboard_if #(
  parameter int TAG_W = 4,
  parameter int SEL_W = 2
);
  logic                    hold;
  logic                    flush;
  logic                    id_valid;
  logic                    id_wb_en;
  logic                    id_mem_r_en;
  logic [TAG_W-1:0]        id_dest;
  logic [TAG_W-1:0]        id_src1;
  logic [TAG_W-1:0]        id_src2;
  logic                    id_two_src;
  logic                    hazard;
  logic [SEL_W-1:0]        fwd_sel1;
  logic [SEL_W-1:0]        fwd_sel2;
  logic [(1<<TAG_W)-1:0]   busy_mask;
  logic [SEL_W-1:0]        inflight_cnt;
  logic [15:0]             stall_cnt;

  modport master (
    output hold, flush, id_valid, id_wb_en, id_mem_r_en, id_dest, id_src1, id_src2, id_two_src,
    input  hazard, fwd_sel1, fwd_sel2, busy_mask, inflight_cnt, stall_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_wb_en, id_mem_r_en, id_dest, id_src1, id_src2, id_two_src,
    output hazard, fwd_sel1, fwd_sel2, busy_mask, inflight_cnt, stall_cnt
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight register writes from EXE to the stage
// before register-file write, and decides per ID operand whether to stall or forward.
module pipeline_scoreboard #(
  parameter int TAG_W      = 4,
  parameter int DEPTH      = 2,
  parameter int FORWARD_EN = 1,
  parameter int LOAD_STAGE = 1,
  parameter int SEL_W      = 2
) (
  input logic                clk,
  input logic                rst,
  pipeline_scoreboard_if.slave sb
);

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0]      ent_load;
  logic [TAG_W-1:0]      ent_dest [DEPTH];

  logic                  hit1, hit2;
  logic [SEL_W-1:0]      age1, age2;
  logic                  haz1, haz2;
  logic [SEL_W-1:0]      sel1, sel2;
  logic [(1<<TAG_W)-1:0] busy;
  logic [SEL_W-1:0]      cnt;
  logic                  issue;
  logic [15:0]           stall_q;

  // Youngest-match search: scanning oldest to youngest lets the youngest hit win.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    age1 = '0;
    age2 = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (ent_valid[k] && ent_dest[k] == sb.id_src1) begin
        hit1 = 1'b1;
        age1 = SEL_W'(k);
      end
      if (ent_valid[k] && ent_dest[k] == sb.id_src2) begin
        hit2 = 1'b1;
        age2 = SEL_W'(k);
      end
    end
  end

  // Per-operand stall/forward decision; a load too young to have its data stalls.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    sel1 = '0;
    sel2 = '0;
    if (FORWARD_EN == 0) begin
      haz1 = sb.id_valid & hit1;
      haz2 = sb.id_valid & sb.id_two_src & hit2;
    end else begin
      if (sb.id_valid && hit1) begin
        if (ent_load[age1] && int'(age1) < LOAD_STAGE) haz1 = 1'b1;
        else                                           sel1 = age1 + SEL_W'(1);
      end
      if (sb.id_valid && sb.id_two_src && hit2) begin
        if (ent_load[age2] && int'(age2) < LOAD_STAGE) haz2 = 1'b1;
        else                                           sel2 = age2 + SEL_W'(1);
      end
    end
  end

  // Occupancy view: per-register busy bits and count of valid entries.
  always_comb begin
    busy = '0;
    cnt  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k]) begin
        busy[ent_dest[k]] = 1'b1;
        cnt               = cnt + SEL_W'(1);
      end
    end
  end

  assign issue = sb.id_valid & sb.id_wb_en & ~sb.hazard & ~sb.flush;

  // Shift pipe: advance one stage per cycle unless the back end holds; bubble when not issuing.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_load  <= '0;
      for (int k = 0; k < DEPTH; k++) ent_dest[k] <= '0;
    end else if (!sb.hold) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_dest[k]  <= ent_dest[k-1];
      end
      ent_valid[0] <= issue;
      ent_load[0]  <= issue & sb.id_mem_r_en;
      ent_dest[0]  <= sb.id_dest;
    end
  end

  // Saturating count of cycles spent frozen, including cycles under hold.
  always_ff @(posedge clk) begin
    if (rst)                                stall_q <= '0;
    else if (sb.hazard && stall_q != '1)    stall_q <= stall_q + 16'd1;
  end

  assign sb.hazard       = haz1 | haz2;
  assign sb.fwd_sel1     = sel1;
  assign sb.fwd_sel2     = sel2;
  assign sb.busy_mask    = busy;
  assign sb.inflight_cnt = cnt;
  assign sb.stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench for pipeline_scoreboard: a forwarding instance and a stall-only instance share one
// ID stimulus stream; both are compared every cycle against an age-ordered entry model.
module tb_pipeline_scoreboard;
  localparam int DEPTH      = 2;
  localparam int LOAD_STAGE = 1;

  typedef struct packed {logic v; logic [3:0] d; logic l;} ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold, flush, id_valid, id_wb_en, id_mem_r_en, id_two_src;
  logic [3:0] id_dest, id_src1, id_src2;

  int checks = 0;
  int errors = 0;

  // model state: index 0 = forwarding instance, 1 = stall-only instance; entry 0 is youngest
  ent_t mdl [2][DEPTH];
  int   mstall [2];

  logic        obs_hz  [2];
  logic [1:0]  obs_s1  [2];
  logic [1:0]  obs_s2  [2];
  logic [15:0] obs_busy[2];
  logic [1:0]  obs_cnt [2];
  logic [15:0] obs_st  [2];

  always #5 clk = ~clk;

  pipeline_scoreboard_if #(.TAG_W(4), .SEL_W(2)) if_f ();
  pipeline_scoreboard_if #(.TAG_W(4), .SEL_W(2)) if_s ();

  assign if_f.hold = hold;          assign if_s.hold = hold;
  assign if_f.flush = flush;        assign if_s.flush = flush;
  assign if_f.id_valid = id_valid;  assign if_s.id_valid = id_valid;
  assign if_f.id_wb_en = id_wb_en;  assign if_s.id_wb_en = id_wb_en;
  assign if_f.id_mem_r_en = id_mem_r_en; assign if_s.id_mem_r_en = id_mem_r_en;
  assign if_f.id_dest = id_dest;    assign if_s.id_dest = id_dest;
  assign if_f.id_src1 = id_src1;    assign if_s.id_src1 = id_src1;
  assign if_f.id_src2 = id_src2;    assign if_s.id_src2 = id_src2;
  assign if_f.id_two_src = id_two_src; assign if_s.id_two_src = id_two_src;

  pipeline_scoreboard #(.TAG_W(4), .DEPTH(DEPTH), .FORWARD_EN(1), .LOAD_STAGE(LOAD_STAGE), .SEL_W(2))
    dut_fwd (.clk(clk), .rst(rst), .sb(if_f));
  pipeline_scoreboard #(.TAG_W(4), .DEPTH(DEPTH), .FORWARD_EN(0), .LOAD_STAGE(LOAD_STAGE), .SEL_W(2))
    dut_stl (.clk(clk), .rst(rst), .sb(if_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One operand: find the youngest in-flight writer of tag t and decide stall or source.
  function automatic void operand(input int c, input bit checked, input logic [3:0] t,
                                  output bit hz, output logic [1:0] sel);
    int k;
    hz  = 1'b0;
    sel = 2'd0;
    k   = -1;
    if (!checked) return;
    for (int i = 0; i < DEPTH; i++) begin
      if (mdl[c][i].v && mdl[c][i].d == t) begin
        k = i;
        break;
      end
    end
    if (k < 0) return;
    if (c == 1 || (mdl[c][k].l && k < LOAD_STAGE)) hz = 1'b1;
    else sel = 2'(k + 1);
  endfunction

  task automatic sample(input int c);
    if (c == 0) begin
      obs_hz[0] = if_f.hazard;  obs_s1[0] = if_f.fwd_sel1; obs_s2[0] = if_f.fwd_sel2;
      obs_busy[0] = if_f.busy_mask; obs_cnt[0] = if_f.inflight_cnt; obs_st[0] = if_f.stall_cnt;
    end else begin
      obs_hz[1] = if_s.hazard;  obs_s1[1] = if_s.fwd_sel1; obs_s2[1] = if_s.fwd_sel2;
      obs_busy[1] = if_s.busy_mask; obs_cnt[1] = if_s.inflight_cnt; obs_st[1] = if_s.stall_cnt;
    end
  endtask

  // Apply one cycle of ID/control inputs, compare both instances, then advance the model.
  task automatic step(input bit r, input bit h, input bit f, input bit vv, input bit w,
                      input bit l, input logic [3:0] de, input logic [3:0] a,
                      input logic [3:0] b, input bit t);
    bit          ehz [2];
    bit          h1, h2;
    logic [1:0]  es1, es2;
    logic [15:0] ebusy;
    int          ecnt;
    string       pfx;
    rst = r; hold = h; flush = f; id_valid = vv; id_wb_en = w; id_mem_r_en = l;
    id_dest = de; id_src1 = a; id_src2 = b; id_two_src = t;
    #1;
    for (int c = 0; c < 2; c++) begin
      pfx = (c == 0) ? "fwd" : "stl";
      operand(c, vv, a, h1, es1);
      operand(c, vv && t, b, h2, es2);
      ehz[c] = h1 | h2;
      ebusy = '0;
      ecnt  = 0;
      for (int i = 0; i < DEPTH; i++) if (mdl[c][i].v) begin
        ebusy[mdl[c][i].d] = 1'b1;
        ecnt++;
      end
      sample(c);
      chk({pfx, "_hazard"}, 32'(obs_hz[c]), 32'(ehz[c]));
      chk({pfx, "_fwd_sel1"}, 32'(obs_s1[c]), 32'(es1));
      chk({pfx, "_fwd_sel2"}, 32'(obs_s2[c]), 32'(es2));
      chk({pfx, "_busy_mask"}, 32'(obs_busy[c]), 32'(ebusy));
      chk({pfx, "_inflight"}, 32'(obs_cnt[c]), 32'(ecnt));
      chk({pfx, "_stall_cnt"}, 32'(obs_st[c]), 32'(mstall[c]));
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (r) begin
        for (int i = 0; i < DEPTH; i++) mdl[c][i] = '0;
        mstall[c] = 0;
      end else begin
        if (ehz[c] && mstall[c] < 65535) mstall[c]++;
        if (!h) begin
          for (int i = DEPTH-1; i >= 1; i--) mdl[c][i] = mdl[c][i-1];
          mdl[c][0] = '{v: vv & w & ~ehz[c] & ~f, d: de, l: l};
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; hold = 0; flush = 0; id_valid = 0; id_wb_en = 0; id_mem_r_en = 0;
    id_dest = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < DEPTH; i++) mdl[c][i] = '0;
      mstall[c] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset with entries pending and a stall counted; rst overrides hold/flush
    step(0,0,0, 1,1,0, 4'd7, 4'd0, 4'd0, 0);
    step(0,0,0, 1,0,0, 4'd0, 4'd7, 4'd0, 0);
    step(1,1,1, 1,1,0, 4'd7, 4'd7, 4'd0, 0);
    step(0,0,0, 0,0,0, 4'd0, 4'd0, 4'd0, 0);
    for (int c = 0; c < 2; c++) begin
      chk("rst_hazard", 32'(obs_hz[c]), 32'd0);
      chk("rst_sel1", 32'(obs_s1[c]), 32'd0);
      chk("rst_busy", 32'(obs_busy[c]), 32'd0);
      chk("rst_cnt", 32'(obs_cnt[c]), 32'd0);
      chk("rst_stall", 32'(obs_st[c]), 32'd0);
    end

    // write R1, then use it: stall-only freezes for two cycles, forwarder picks 1 then 2
    step(0,0,0, 1,1,0, 4'd1, 4'd0, 4'd0, 0);
    step(0,0,0, 1,0,0, 4'd0, 4'd1, 4'd0, 0);
    chk("t2_haz_c1", 32'(obs_hz[1]), 32'd1);
    chk("t2_fsel_c1", 32'(obs_s1[0]), 32'd1);
    step(0,0,0, 1,0,0, 4'd0, 4'd1, 4'd0, 0);
    chk("t2_haz_c2", 32'(obs_hz[1]), 32'd1);
    chk("t2_fsel_c2", 32'(obs_s1[0]), 32'd2);
    step(0,0,0, 1,0,0, 4'd0, 4'd1, 4'd0, 0);
    chk("t2_haz_c3", 32'(obs_hz[1]), 32'd0);
    chk("t2_stall", 32'(obs_st[1]), 32'd2);

    // ALU write R2 forwarded from entry 0, then from entry 1
    step(0,0,0, 1,1,0, 4'd2, 4'd0, 4'd0, 0);
    step(0,0,0, 1,0,0, 4'd0, 4'd2, 4'd0, 0);
    chk("t3_haz", 32'(obs_hz[0]), 32'd0);
    chk("t3_sel_e0", 32'(obs_s1[0]), 32'd1);
    step(0,0,0, 1,0,0, 4'd0, 4'd2, 4'd0, 0);
    chk("t3_sel_e1", 32'(obs_s1[0]), 32'd2);

    // load R3 used as src2: one-cycle load-use stall, then forward; unchecked src2 ignored
    step(0,0,0, 1,1,1, 4'd3, 4'd0, 4'd0, 0);
    step(0,0,0, 1,0,0, 4'd0, 4'd0, 4'd3, 1);
    chk("t4_ld_haz", 32'(obs_hz[0]), 32'd1);
    step(0,0,0, 1,0,0, 4'd0, 4'd0, 4'd3, 1);
    chk("t4_ld_haz_clr", 32'(obs_hz[0]), 32'd0);
    chk("t4_ld_sel2", 32'(obs_s2[0]), 32'd2);
    step(0,0,0, 1,1,1, 4'd3, 4'd0, 4'd0, 0);
    step(0,0,0, 1,0,0, 4'd0, 4'd0, 4'd3, 0);
    chk("t4_one_src_haz", 32'(obs_hz[0]), 32'd0);
    chk("t4_one_src_sel2", 32'(obs_s2[0]), 32'd0);

    // R4 twice: youngest wins; hold freezes everything; flushed issue becomes a bubble
    step(0,0,0, 1,1,0, 4'd4, 4'd0, 4'd0, 0);
    step(0,0,0, 1,1,0, 4'd4, 4'd0, 4'd0, 0);
    for (int n = 0; n < 3; n++) begin
      step(0,1,0, 1,0,0, 4'd0, 4'd4, 4'd0, 0);
      chk("t5_hold_sel1", 32'(obs_s1[0]), 32'd1);
      chk("t5_hold_busy", 32'(obs_busy[0]), 32'h0010);
      chk("t5_hold_cnt", 32'(obs_cnt[0]), 32'd2);
    end
    step(0,0,1, 1,1,0, 4'd5, 4'd0, 4'd0, 0);
    step(0,0,0, 0,0,0, 4'd0, 4'd0, 4'd0, 0);
    chk("t5_flush_cnt", 32'(obs_cnt[0]), 32'd1);
    chk("t5_flush_busy", 32'(obs_busy[0]), 32'h0010);

    // randomized traffic over a small tag range so matches are frequent
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1);
    end

    // stall counter saturation under a held load-use hazard, then reset
    step(1,0,0, 0,0,0, 4'd0, 4'd0, 4'd0, 0);
    step(0,0,0, 1,1,1, 4'd6, 4'd0, 4'd0, 0);
    step(0,1,0, 1,0,0, 4'd0, 4'd6, 4'd0, 0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) mstall[c] = (mstall[c] + 70000 > 65535) ? 65535 : mstall[c] + 70000;
    step(0,1,0, 1,0,0, 4'd0, 4'd6, 4'd0, 0);
    chk("t6_sat_fwd", 32'(obs_st[0]), 32'h0000FFFF);
    chk("t6_sat_stl", 32'(obs_st[1]), 32'h0000FFFF);
    step(1,1,0, 1,0,0, 4'd0, 4'd6, 4'd0, 0);
    step(0,0,0, 0,0,0, 4'd0, 4'd0, 4'd0, 0);
    chk("t6_rst_stall", 32'(obs_st[0]), 32'd0);
    chk("t6_rst_cnt", 32'(obs_cnt[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
